// File: rtl/noc_switch_allocator_pkg.sv
// Shared definitions for the 5-port XY mesh router switch allocator.
//   NUM_PORTS  : number of router ports (local, north, south, east, west)
//   COORD_W    : width of one mesh coordinate
//   PORT_*     : port index constants, also used as output/input slice index
//   xy_route() : dimension-ordered (X first, then Y) output port selection
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned COORD_W   = 2;

  typedef logic [2:0]         port_idx_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam port_idx_t PORT_LOCAL = 3'd0;
  localparam port_idx_t PORT_NORTH = 3'd1;
  localparam port_idx_t PORT_SOUTH = 3'd2;
  localparam port_idx_t PORT_EAST  = 3'd3;
  localparam port_idx_t PORT_WEST  = 3'd4;

  // X is resolved before Y; a flit addressed to this router goes local.
  function automatic port_idx_t xy_route(input coord_t dest_x, input coord_t dest_y,
                                         input coord_t cur_x, input coord_t cur_y);
    if (dest_x > cur_x)      return PORT_EAST;
    else if (dest_x < cur_x) return PORT_WEST;
    else if (dest_y > cur_y) return PORT_SOUTH;
    else if (dest_y < cur_y) return PORT_NORTH;
    else                     return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/noc_switch_allocator_if.sv
// Bundle of the allocator's per-port data paths.
//   in_data/in_valid : head flit of each input FIFO (slice i = [i*WIDTH +: WIDTH])
//   pop              : read enable back to each input FIFO
//   out_data/out_valid/out_ready : registered output stage with handshake
// Modports: slave = allocator side, master = FIFO/downstream side.
interface noc_switch_allocator_if #(
  parameter int unsigned WIDTH = 8
);
  import noc_pkg::*;

  logic [NUM_PORTS*WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]       in_valid;
  logic [NUM_PORTS-1:0]       pop;
  logic [NUM_PORTS*WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]       out_valid;
  logic [NUM_PORTS-1:0]       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  pop, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output pop, out_data, out_valid
  );

endinterface

// File: rtl/noc_switch_allocator_rr_arbiter.sv
// Round-robin arbiter for one output port.
//   clk, rst : clock, asynchronous active-high reset (pointer returns to 0)
//   req      : one bit per input port requesting this output
//   enable   : output is free to accept a new flit this cycle
//   grant    : one-hot winner (all zero when disabled or no request)
// The pointer names the highest-priority input; after a grant it moves to
// the input just past the winner, wrapping 4 -> 0.
module noc_rr_arbiter
  import noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 enable,
  output logic [NUM_PORTS-1:0] grant
);

  port_idx_t ptr;
  port_idx_t win;
  port_idx_t idx;
  logic      found;

  always_comb begin
    grant = '0;
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = port_idx_t'((32'(ptr) + k) % NUM_PORTS);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (win == port_idx_t'(NUM_PORTS - 1)) ? '0 : win + 3'd1;
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Central crossbar scheduler for the 5-port XY mesh router.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of noc_switch_allocator_if (FIFO heads in, pops
//              out, registered output stages with valid/ready)
// Every input head is XY-routed to exactly one output; each output picks a
// winner with its own round-robin arbiter whenever it is free (empty or being
// drained this cycle), pops the winner and registers its flit.
module noc_switch_allocator
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CUR_X = 1,
  parameter int unsigned CUR_Y = 1
) (
  input logic                  clk,
  input logic                  rst,
  noc_switch_allocator_if.slave bus
);

  localparam coord_t CX = coord_t'(CUR_X);
  localparam coord_t CY = coord_t'(CUR_Y);

  logic [WIDTH-1:0]     flit       [NUM_PORTS];
  port_idx_t            route      [NUM_PORTS];
  logic [NUM_PORTS-1:0] req        [NUM_PORTS];  // req[output][input]
  logic [NUM_PORTS-1:0] gnt        [NUM_PORTS];  // gnt[output][input]
  logic [WIDTH-1:0]     nxt_data   [NUM_PORTS];
  logic [WIDTH-1:0]     out_data_q [NUM_PORTS];
  logic                 out_valid_q[NUM_PORTS];
  logic [NUM_PORTS-1:0] free;
  logic [NUM_PORTS-1:0] pop_any;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    assign flit[i]  = bus.in_data[i*WIDTH +: WIDTH];
    assign route[i] = xy_route(flit[i][WIDTH-1 -: COORD_W],
                               flit[i][WIDTH-1-COORD_W -: COORD_W], CX, CY);
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
      assign req[o][i] = bus.in_valid[i] && (route[i] == port_idx_t'(o));
    end

    // Draining and refilling in the same cycle keeps out_valid high.
    assign free[o] = !out_valid_q[o] || bus.out_ready[o];

    noc_rr_arbiter u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req[o]),
      .enable (free[o]),
      .grant  (gnt[o])
    );

    always_comb begin
      nxt_data[o] = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (gnt[o][k[2:0]]) nxt_data[o] = flit[k[2:0]];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid_q[o] <= 1'b0;
        out_data_q[o]  <= '0;
      end else if (free[o]) begin
        out_valid_q[o] <= |gnt[o];
        if (|gnt[o]) out_data_q[o] <= nxt_data[o];
      end
    end

    assign bus.out_valid[o]                = out_valid_q[o];
    assign bus.out_data[o*WIDTH +: WIDTH] = out_data_q[o];
  end

  always_comb begin
    pop_any = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      pop_any = pop_any | gnt[k[2:0]];
    end
    bus.pop = rst ? '0 : pop_any;
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
module tb_noc_switch_allocator;
  localparam int NP = 5;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  noc_switch_allocator_if #(.WIDTH(W)) bus ();

  noc_switch_allocator #(.WIDTH(W), .CUR_X(1), .CUR_Y(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: output registers and per-output priority pointer.
  int             m_ptr [NP];
  logic [NP-1:0]  m_ov;
  logic [W-1:0]   m_od  [NP];
  int             m_win [NP];
  logic [NP-1:0]  m_pop;

  // Router sits at (1,1): X first, then Y.
  function automatic int dest_port(logic [W-1:0] f);
    int dx;
    int dy;
    dx = int'(f[7:6]);
    dy = int'(f[5:4]);
    if (dx > 1) return 3;
    if (dx < 1) return 4;
    if (dy > 1) return 2;
    if (dy < 1) return 1;
    return 0;
  endfunction

  function automatic logic [NP*W-1:0] model_data();
    logic [NP*W-1:0] v;
    for (int o = 0; o < NP; o++) v[o*W +: W] = m_od[o];
    return v;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_ptr[o] = 0;
      m_od[o]  = '0;
    end
    m_ov = '0;
  endtask

  task automatic model_eval();
    m_pop = '0;
    for (int o = 0; o < NP; o++) begin
      m_win[o] = -1;
      if (!m_ov[o] || bus.out_ready[o]) begin
        for (int k = 0; k < NP; k++) begin
          int i;
          i = (m_ptr[o] + k) % NP;
          if (m_win[o] < 0 && bus.in_valid[i] && dest_port(bus.in_data[i*W +: W]) == o)
            m_win[o] = i;
        end
      end
      if (m_win[o] >= 0) m_pop[m_win[o]] = 1'b1;
    end
  endtask

  task automatic model_clock();
    for (int o = 0; o < NP; o++) begin
      if (m_win[o] >= 0) begin
        m_od[o]  = bus.in_data[m_win[o]*W +: W];
        m_ov[o]  = 1'b1;
        m_ptr[o] = (m_win[o] + 1) % NP;
      end else if (!m_ov[o] || bus.out_ready[o]) begin
        m_ov[o] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_flit(int i, logic [W-1:0] d);
    bus.in_data[i*W +: W] = d;
  endtask

  task automatic test_reset();
    bus.in_valid  = '1;
    bus.in_data   = {NP{8'h50}};
    bus.out_ready = '1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.pop !== 5'b00000) begin
      failures++; $display("FAIL reset_pop: got %b expected 00000", bus.pop);
    end
    checks++;
    if (bus.out_valid !== 5'b00000) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 00000", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      failures++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pop !== 5'b00001) begin
      failures++; $display("FAIL reset_first_grant: got %b expected 00001", bus.pop);
    end
    tick();
    checks++;
    if (bus.out_valid !== 5'b00001 || bus.out_data[0 +: W] !== 8'h50) begin
      failures++;
      $display("FAIL reset_first_out: got valid=%b data0=%h expected valid=00001 data0=50",
               bus.out_valid, bus.out_data[0 +: W]);
    end
  endtask

  task automatic test_contention();
    logic [NP-1:0] seq [4];
    seq[0] = 5'b00010; seq[1] = 5'b00100; seq[2] = 5'b10000; seq[3] = 5'b00010;
    bus.in_valid  = 5'b10110;
    bus.in_data   = {NP{8'h50}};
    bus.out_ready = '1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus.pop !== seq[c]) begin
        failures++; $display("FAIL contention_pop[%0d]: got %b expected %b", c, bus.pop, seq[c]);
      end
      tick();
      checks++;
      if (bus.out_valid[0] !== 1'b1 || bus.out_data[0 +: W] !== 8'h50) begin
        failures++;
        $display("FAIL contention_out[%0d]: got valid0=%b data0=%h expected 1/50",
                 c, bus.out_valid[0], bus.out_data[0 +: W]);
      end
    end
  endtask

  task automatic test_single_route();
    bus.in_valid  = 5'b00001;
    bus.in_data   = '0;
    set_flit(0, 8'h90);
    bus.out_ready = '1;
    #1;
    checks++;
    if (bus.pop !== 5'b00001) begin
      failures++; $display("FAIL single_pop: got %b expected 00001", bus.pop);
    end
    tick();
    bus.in_valid = '0;
    checks++;
    if (bus.out_valid !== 5'b01000 || bus.out_data[3*W +: W] !== 8'h90) begin
      failures++;
      $display("FAIL single_out: got valid=%b data3=%h expected 01000/90",
               bus.out_valid, bus.out_data[3*W +: W]);
    end
  endtask

  task automatic test_backpressure();
    bus.in_valid  = 5'b00001;
    set_flit(0, 8'hB0);
    bus.out_ready = '1;
    #1;
    checks++;
    if (bus.pop !== 5'b00001) begin
      failures++; $display("FAIL bp_load_pop: got %b expected 00001", bus.pop);
    end
    tick();
    set_flit(0, 8'hA0);
    bus.out_ready = 5'b10111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.pop !== 5'b00000) begin
        failures++; $display("FAIL bp_stall_pop[%0d]: got %b expected 00000", c, bus.pop);
      end
      tick();
      checks++;
      if (bus.out_valid[3] !== 1'b1 || bus.out_data[3*W +: W] !== 8'hB0) begin
        failures++;
        $display("FAIL bp_stall_out[%0d]: got valid3=%b data3=%h expected 1/b0",
                 c, bus.out_valid[3], bus.out_data[3*W +: W]);
      end
    end
    bus.out_ready = '1;
    #1;
    checks++;
    if (bus.pop !== 5'b00001) begin
      failures++; $display("FAIL bp_release_pop: got %b expected 00001", bus.pop);
    end
    tick();
    bus.in_valid = '0;
    checks++;
    if (bus.out_valid[3] !== 1'b1 || bus.out_data[3*W +: W] !== 8'hA0) begin
      failures++;
      $display("FAIL bp_release_out: got valid3=%b data3=%h expected 1/a0",
               bus.out_valid[3], bus.out_data[3*W +: W]);
    end
  endtask

  task automatic test_parallel();
    bus.in_valid  = 5'b01101;
    bus.in_data   = '0;
    set_flit(0, 8'h90);
    set_flit(3, 8'h10);
    set_flit(2, 8'h40);
    bus.out_ready = '1;
    #1;
    checks++;
    if (bus.pop !== 5'b01101) begin
      failures++; $display("FAIL parallel_pop: got %b expected 01101", bus.pop);
    end
    tick();
    bus.in_valid = '0;
    checks++;
    if (bus.out_valid !== 5'b11010 || bus.out_data[3*W +: W] !== 8'h90 ||
        bus.out_data[4*W +: W] !== 8'h10 || bus.out_data[1*W +: W] !== 8'h40) begin
      failures++;
      $display("FAIL parallel_out: got valid=%b data=%h expected valid=11010 d3=90 d4=10 d1=40",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  h [NP];
    logic [NP-1:0] v;
    int            waits [NP];
    int            max_wait;
    v = '0;
    max_wait = 0;
    for (int i = 0; i < NP; i++) begin
      h[i] = '0;
      waits[i] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (!v[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          h[i] = W'($urandom);
          waits[i] = 0;
        end
        set_flit(i, h[i]);
      end
      bus.in_valid  = v;
      bus.out_ready = NP'($urandom_range(0, 31) | $urandom_range(0, 31));
      #1;
      model_eval();
      checks++;
      if (bus.pop !== m_pop) begin
        failures++; $display("FAIL rand_pop[%0d]: got %b expected %b", cyc, bus.pop, m_pop);
      end
      // A waiting head may see at most 4 other winners on its output.
      for (int i = 0; i < NP; i++) begin
        if (v[i] && !bus.pop[i]) begin
          for (int j = 0; j < NP; j++) begin
            if (j != i && bus.pop[j] && dest_port(h[j]) == dest_port(h[i])) waits[i]++;
          end
          if (waits[i] > max_wait) max_wait = waits[i];
        end
      end
      for (int i = 0; i < NP; i++) if (bus.pop[i]) v[i] = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== m_ov || bus.out_data !== model_data()) begin
        failures++;
        $display("FAIL rand_out[%0d]: got valid=%b data=%h expected valid=%b data=%h",
                 cyc, bus.out_valid, bus.out_data, m_ov, model_data());
      end
    end
    bus.in_valid = '0;
    checks++;
    if (max_wait > 4) begin
      failures++; $display("FAIL rand_fairness: got max wait %0d expected <= 4", max_wait);
    end
  endtask

  task automatic test_reset_mid();
    bus.in_valid  = 5'b00100;
    bus.in_data   = '0;
    set_flit(2, 8'h40);
    bus.out_ready = '1;
    #1;
    checks++;
    if (bus.pop !== 5'b00100) begin
      failures++; $display("FAIL midrst_load_pop: got %b expected 00100", bus.pop);
    end
    tick();
    checks++;
    if (bus.out_valid[1] !== 1'b1) begin
      failures++; $display("FAIL midrst_loaded: got valid1=%b expected 1", bus.out_valid[1]);
    end
    bus.in_valid = '1;
    bus.in_data  = {NP{8'h40}};
    bus.out_ready = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 5'b00000 || bus.out_data !== '0 || bus.pop !== 5'b00000) begin
      failures++;
      $display("FAIL midrst_async: got valid=%b data=%h pop=%b expected all zero",
               bus.out_valid, bus.out_data, bus.pop);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = '1;
    for (int k = 0; k < NP; k++) begin
      #1;
      checks++;
      if (bus.pop !== NP'(1 << k)) begin
        failures++; $display("FAIL midrst_order[%0d]: got %b expected %b", k, bus.pop, NP'(1 << k));
      end
      tick();
    end
    bus.in_valid = '0;
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = '0;
    model_reset();
    test_reset();
    test_contention();
    test_single_route();
    test_backpressure();
    test_parallel();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_switch_allocator.md
Name: noc_switch_allocator

Overview:
- Central crossbar scheduler for the 5-port XY mesh router.
- Takes the head flit of each of the five input FIFOs (local, north, south, east, west) and computes the XY route for every head.
- Arbitrates each output port among its requesters with a per-output round-robin.
- Pops the winning FIFOs and drives registered output stages with valid/ready handshake.
- Replaces the local-only routing path, so all five inputs are forwarded concurrently.

Parameters:
- WIDTH, 8, flit width; must be ≥4. dest_x = flit[WIDTH-1:WIDTH-2], dest_y = flit[WIDTH-3:WIDTH-4].
- CUR_X, 1, this router's X coordinate (2 bits).
- CUR_Y, 1, this router's Y coordinate (2 bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  5*WIDTH  FIFO head flits; slice i = [i*WIDTH +: WIDTH]; port index 0=local, 1=north, 2=south, 3=east, 4=west.
- in_valid  in  5  FIFO i non-empty; head valid.
- pop  out  5  combinational read enable to FIFO i; head consumed at this clock edge.
- out_data  out  5*WIDTH  registered output flit per output port, same indexing.
- out_valid  out  5  registered output valid.
- out_ready  in  5  downstream accepts out_data[o] at this edge.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, all round-robin pointers=0. pop is 0 while rst is high.
- Route compute, combinational, per input i, evaluated in this order:
  - dest_x>CUR_X → east
  - dest_x<CUR_X → west
  - dest_y>CUR_Y → south
  - dest_y<CUR_Y → north
  - else → local
  - Unsigned 2-bit compares. Each input targets exactly one output, so pop is never multi-output.
- Output o is "free" when out_valid[o]==0 or out_ready[o]==1.
- Arbitration per output o:
  - req[o][i] = in_valid[i] && route(i)==o.
  - If o is free and any req is set, grant the first i scanning ptr[o], ptr[o]+1, … mod 5.
  - pop[i] = grant. ptr[o] <= (granted i + 1) mod 5 at the edge. Wrap from 4 to 0.
- Output register at the edge:
  - Granted: out_data[o] <= in_data[granted]; out_valid[o] <= 1.
  - Free, no grant: out_valid[o] <= 0; out_data[o] holds.
  - Not free (valid && !ready): out_data/out_valid hold; no grant; ptr holds.
- Latency: pop in cycle N → out_valid in cycle N+1. Throughput: 1 flit/cycle per output, with up to 5 outputs in parallel.
- Simultaneous drain and refill: output holding a flit with out_ready=1 and a new grant → new flit loaded, out_valid stays 1, no bubble.
- U-turn routes (e.g. a north input resolving to north) are legal and not special-cased.
- A losing requester keeps in_valid high; its flit is not dropped and it wins within 4 grants of that output.
- Reset mid-operation: in-flight output flits are discarded; pointers return to 0.
- No state machine beyond the per-output pointer and output register; no combinational path from out_ready to out_data.

Decomposition:
- Shared package noc_pkg:
  - NUM_PORTS=5.
  - Port index constants PORT_LOCAL..PORT_WEST.
  - COORD_W=2.
  - Function xy_route(dest_x, dest_y, cur_x, cur_y), returns a port index.
- Sub-module noc_rr_arbiter, instantiated five times (one per output):
  - Inputs: 5-bit req, enable (= output free).
  - Outputs: one-hot 5-bit grant.
  - State: internal 3-bit pointer, updated only when enable && |req.

Test Plan:
1. Reset: assert rst with in_valid=5'h1F → pop=0, out_valid=0, out_data=0 immediately. Release → first grant order starts at index 0.
2. Single route (CUR=1,1): local in_data=8'h90 (x=2, y=1) → pop[0]=1 in cycle 0; cycle 1 out_valid[3]=1, out_data[3]=8'h90; all other outputs idle.
3. Contention: north, south, west each present 8'h50 continuously (local destination), out_ready[0]=1 → pop sequence north, south, west, north, one per cycle; out_valid[0] stays high.
4. Backpressure: out_valid[3]=1 with out_ready[3]=0 for 3 cycles, local holding 8'hA0 → pop[0]=0 and out_data[3] stable. Raise ready → 8'hA0 popped that cycle, appears the next cycle.
5. Parallel: local 8'h90→east, east 8'h10→west, south 8'h40→north in the same cycle → all three pop together; the next cycle shows out_valid=5'b11010 with the matching data.
6. Reset mid-transfer: assert rst while out_valid[1]=1 and ptr nonzero → out_valid clears asynchronously; after release, the next contention round grants from index 0.
